// File: rtl/sb_pkg.sv
// Shared types and constants for the sideband receive path: FSM states,
// recognised opcodes, header field positions and the message parity rule.
package sb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PATTERN_DET = 2'd1,
        WAIT_DATA   = 2'd2,
        HOLD        = 2'd3
    } sb_rx_state_e;

    localparam logic [4:0] MSG_NO_DATA   = 5'b10010;
    localparam logic [4:0] MSG_WITH_DATA = 5'b11011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 4;
    localparam int CP_BIT  = 62;
    localparam int DP_BIT  = 63;

    // CP covers header bits below it; DP covers the data word, or is 0 when there is none.
    function automatic logic parity_ok(input logic [63:0] hdr,
                                       input logic [63:0] data,
                                       input logic        has_data);
        logic exp_cp;
        logic exp_dp;
        exp_cp = ^hdr[CP_BIT-1:0];
        exp_dp = has_data ? ^data : 1'b0;
        return (hdr[CP_BIT] == exp_cp) && (hdr[DP_BIT] == exp_dp);
    endfunction

endpackage

// File: rtl/sb_rx_pattern_det.sv
// Init-pattern matcher: counts consecutive PATTERN words while enabled and
// emits a registered one-cycle detection pulse once MATCH_CNT are seen.
module sb_rx_pattern_det #(
    parameter int                DATA_W    = 64,
    parameter int                MATCH_CNT = 2,
    parameter logic [DATA_W-1:0] PATTERN   = 64'hAAAA_AAAA_AAAA_AAAA
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_word_valid,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_hit,
    output logic              o_detected
);

    localparam int CNT_W = $clog2(MATCH_CNT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;
    logic             det_q;

    always_comb begin
        cnt_d = cnt_q;
        hit   = 1'b0;
        if (!i_en) begin
            cnt_d = '0;
        end else if (i_word_valid) begin
            if (i_word == PATTERN) begin
                if (cnt_q == CNT_W'(MATCH_CNT - 1)) begin
                    cnt_d = '0;
                    hit   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            det_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            det_q <= hit;
        end
    end

    assign o_hit      = hit;
    assign o_detected = det_q;

endmodule

// File: rtl/sb_rx_fsm.sv
// Sideband RX controller: assembles header(+data) messages, hands them off with
// valid/ack, detects the init pattern. Parity check enabled by SB_RX_PARITY_CHK_EN.
//
// Handshake: o_msg_valid stays high while a message is held; the consumer
// pulses i_msg_ack for one cycle and o_msg_valid falls on the following cycle.
module sb_rx_fsm
    import sb_pkg::*;
#(
    parameter int                DATA_W            = 64,
    parameter int                PATTERN_MATCH_CNT = 2,
    parameter logic [DATA_W-1:0] PATTERN_WORD      = 64'hAAAA_AAAA_AAAA_AAAA
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pattern_detect_en,
    input  logic              i_word_valid,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_msg_ack,
    output logic [DATA_W-1:0] o_header,
    output logic [DATA_W-1:0] o_data,
    output logic              o_has_data,
    output logic              o_msg_valid,
    output logic              o_pattern_detected,
    output logic              o_overrun,
    output logic              o_unsupported,
    output logic              o_parity_err,
    output logic              o_busy,
    output sb_rx_state_e      o_dbg_state
);

    sb_rx_state_e      state_q, state_d;
    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              has_data_q, has_data_d;
    logic              ovr_q, ovr_d;
    logic              unsup_q, unsup_d;
    logic              par_q, par_d;
    logic              pat_hit;

    sb_rx_pattern_det #(
        .DATA_W   (DATA_W),
        .MATCH_CNT(PATTERN_MATCH_CNT),
        .PATTERN  (PATTERN_WORD)
    ) u_pattern_det (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        ((state_q == PATTERN_DET) && i_pattern_detect_en),
        .i_word_valid(i_word_valid),
        .i_word      (i_word),
        .o_hit       (pat_hit),
        .o_detected  (o_pattern_detected)
    );

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        data_d     = data_q;
        has_data_d = has_data_q;
        ovr_d      = 1'b0;
        unsup_d    = 1'b0;
        par_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A detect request wins over a word arriving in the same cycle.
                if (i_pattern_detect_en) begin
                    state_d = PATTERN_DET;
                end else if (i_word_valid) begin
                    hdr_d      = i_word;
                    has_data_d = 1'b0;
                    if (i_word[OPC_MSB:OPC_LSB] == MSG_NO_DATA) begin
                        data_d = '0;
`ifdef SB_RX_PARITY_CHK_EN
                        if (parity_ok(i_word, '0, 1'b0)) state_d = HOLD;
                        else                             par_d   = 1'b1;
`else
                        state_d = HOLD;
`endif
                    end else if (i_word[OPC_MSB:OPC_LSB] == MSG_WITH_DATA) begin
                        state_d = WAIT_DATA;
                    end else begin
                        unsup_d = 1'b1;
                    end
                end
            end
            PATTERN_DET: begin
                if (!i_pattern_detect_en || pat_hit) state_d = IDLE;
            end
            WAIT_DATA: begin
                if (i_word_valid) begin
                    data_d     = i_word;
                    has_data_d = 1'b1;
`ifdef SB_RX_PARITY_CHK_EN
                    if (parity_ok(hdr_q, i_word, 1'b1)) begin
                        state_d = HOLD;
                    end else begin
                        par_d   = 1'b1;
                        state_d = IDLE;
                    end
`else
                    state_d = HOLD;
`endif
                end
            end
            HOLD: begin
                if (i_word_valid) ovr_d   = 1'b1;
                if (i_msg_ack)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            hdr_q      <= '0;
            data_q     <= '0;
            has_data_q <= 1'b0;
            ovr_q      <= 1'b0;
            unsup_q    <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            data_q     <= data_d;
            has_data_q <= has_data_d;
            ovr_q      <= ovr_d;
            unsup_q    <= unsup_d;
            par_q      <= par_d;
        end
    end

    assign o_header      = hdr_q;
    assign o_data        = data_q;
    assign o_has_data    = has_data_q;
    assign o_msg_valid   = (state_q == HOLD);
    assign o_busy        = (state_q == WAIT_DATA) || (state_q == HOLD);
    assign o_overrun     = ovr_q;
    assign o_unsupported = unsup_q;
    assign o_dbg_state   = state_q;
`ifdef SB_RX_PARITY_CHK_EN
    assign o_parity_err  = par_q;
`else
    assign o_parity_err  = 1'b0;
`endif

endmodule
